serial_addsub: RTL and testbench



---
 rtl/serial_addsub_if.sv | 27 ++
 rtl/serial_addsub.sv | 110 +++++++++++
 tb/tb_serial_addsub.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - request/response bundle for the bit-serial adder/subtractor
interface serial_addsub_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             ctrl_sub;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_result;
    logic             overflow;
    logic             isNotEqual;
    logic             isLessThan;

    // Requester side: issues operands and opcode, observes status and result
    modport master (
        output start, ctrl_sub, data_operandA, data_operandB,
        input  busy, done, data_result, overflow, isNotEqual, isLessThan
    );

    // Arithmetic unit side
    modport slave (
        input  start, ctrl_sub, data_operandA, data_operandB,
        output busy, done, data_result, overflow, isNotEqual, isLessThan
    );
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial add/subtract through one full-adder slice, LSB first
module serial_addsub #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           resetn,
    serial_addsub_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Bit 0 of the partial result is never needed: the final edge shifts it out
    logic [WIDTH-1:1] r_sh;
    logic             carry;
    logic             nz;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             cout;
    logic             last;
    logic             ov;
    logic [WIDTH-1:0] r_nx;

    // Single full-adder slice fed from the low ends of the operand shifters
    assign s    = a_sh[0] ^ b_sh[0] ^ carry;
    assign cout = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last = (cnt == LAST);
    assign ov   = carry ^ cout;
    assign r_nx = {s, r_sh};

    // Status comes straight from the state register, so it is glitch-free
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: accept only in IDLE, leave RUN on the MSB slice, DONE lasts one cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Datapath: load on accept, one slice per RUN edge, publish results on the MSB slice
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_sh            <= '0;
            b_sh            <= '0;
            r_sh            <= '0;
            carry           <= 1'b0;
            nz              <= 1'b0;
            cnt             <= '0;
            bus.data_result <= '0;
            bus.overflow    <= 1'b0;
            bus.isNotEqual  <= 1'b0;
            bus.isLessThan  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is A + ~B + 1; the +1 enters as the initial carry
                        a_sh  <= bus.data_operandA;
                        b_sh  <= bus.ctrl_sub ? ~bus.data_operandB : bus.data_operandB;
                        carry <= bus.ctrl_sub;
                        cnt   <= '0;
                        nz    <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    r_sh  <= r_nx[WIDTH-1:1];
                    carry <= cout;
                    nz    <= nz | s;
                    if (!last) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (last) begin
                        // Carry into vs. out of the sign slice gives signed overflow;
                        // sign ^ overflow is the true sign of A-B
                        bus.data_result <= r_nx;
                        bus.overflow    <= ov;
                        bus.isNotEqual  <= nz | s;
                        bus.isLessThan  <= s ^ ov;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed and random checks of the bit-serial adder/subtractor
module tb_serial_addsub;
    localparam int WIDTH = 32;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   tests  = 0;
    int   fails  = 0;
    int   edge_cnt = 0;

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},   {31'd0, bus.busy},       32'd0);
        check({tag, ".done"},   {31'd0, bus.done},       32'd0);
        check({tag, ".result"}, bus.data_result,         32'd0);
        check({tag, ".ov"},     {31'd0, bus.overflow},   32'd0);
        check({tag, ".ne"},     {31'd0, bus.isNotEqual}, 32'd0);
        check({tag, ".lt"},     {31'd0, bus.isLessThan}, 32'd0);
    endtask

    // Present a request for exactly one rising edge (E0); returns at the falling edge after E0
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sub);
        @(negedge clock);
        bus.start         = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_sub      = sub;
        @(posedge clock);
        @(negedge clock);
        bus.start         = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        bus.ctrl_sub      = 1'b0;
    endtask

    // Full operation: cycle 1 is the one following E0; done must first show in cycle WIDTH+1
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] e_res, input logic e_ov,
                          input logic e_ne, input logic e_lt, input bit chk_lat);
        int cyc;
        launch(a, b, sub);
        cyc = 1;
        if (chk_lat) check({tag, ".busy_rise"}, {31'd0, bus.busy}, 32'd1);
        while (!bus.done && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        if (chk_lat) check({tag, ".latency"}, cyc, WIDTH + 1);
        check({tag, ".result"}, bus.data_result,         e_res);
        check({tag, ".ov"},     {31'd0, bus.overflow},   {31'd0, e_ov});
        check({tag, ".ne"},     {31'd0, bus.isNotEqual}, {31'd0, e_ne});
        check({tag, ".lt"},     {31'd0, bus.isLessThan}, {31'd0, e_lt});
        @(negedge clock);
        if (chk_lat) begin
            check({tag, ".done_pulse"}, {31'd0, bus.done}, 32'd0);
            check({tag, ".busy_fall"},  {31'd0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] hs_a   [3];
        logic [31:0] hs_b   [3];
        logic        hs_sub [3];
        logic [31:0] hs_res [3];
        int          t_done [3];
        int          t0;
        int          n;
        int          ndone;
        logic [31:0] prev;
        logic [32:0] ext;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        bus.start         = 1'b0;
        bus.ctrl_sub      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;

        // Reset state
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        resetn = 1'b1;

        // Directed vectors, expectations worked by hand
        run_op("add_5_3",     32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("add_max_1",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
        run_op("sub_min_1",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1);
        run_op("sub_7_7",     32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("sub_m2_3",    32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b1, 1'b1);

        // start held high: one acceptance per WIDTH+2 edges, result held until each DONE entry
        hs_a[0] = 32'h0000_0001; hs_b[0] = 32'h0000_0002; hs_sub[0] = 1'b0; hs_res[0] = 32'h0000_0003;
        hs_a[1] = 32'h0000_000A; hs_b[1] = 32'h0000_0003; hs_sub[1] = 1'b1; hs_res[1] = 32'h0000_0007;
        hs_a[2] = 32'h0000_0100; hs_b[2] = 32'h0000_0100; hs_sub[2] = 1'b0; hs_res[2] = 32'h0000_0200;
        prev  = 32'hFFFF_FFFB;
        ndone = 0;
        @(negedge clock);
        bus.start         = 1'b1;
        bus.data_operandA = hs_a[0];
        bus.data_operandB = hs_b[0];
        bus.ctrl_sub      = hs_sub[0];
        t0 = edge_cnt + 1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            t_done[i] = 0;
            while (n < 60) begin
                @(negedge clock);
                n++;
                if (n == 10) check($sformatf("held.hold%0d", i), bus.data_result, prev);
                if (bus.done) begin
                    ndone++;
                    t_done[i] = edge_cnt;
                    break;
                end
            end
            check($sformatf("held.result%0d", i), bus.data_result, hs_res[i]);
            prev = hs_res[i];
            if (i < 2) begin
                bus.data_operandA = hs_a[i + 1];
                bus.data_operandB = hs_b[i + 1];
                bus.ctrl_sub      = hs_sub[i + 1];
            end else begin
                bus.start = 1'b0;
            end
        end
        check("held.first_done", t_done[0] - t0, WIDTH);
        check("held.gap01", t_done[1] - t_done[0], WIDTH + 2);
        check("held.gap12", t_done[2] - t_done[1], WIDTH + 2);
        repeat (50) begin
            @(negedge clock);
            if (bus.done) ndone++;
        end
        check("held.done_count", ndone, 3);

        // Asynchronous reset in the middle of RUN aborts with no done
        launch(32'h0000_1234, 32'h0000_0001, 1'b0);
        repeat (9) @(posedge clock);
        #2 resetn = 1'b0;
        #1 check_all_zero("midrun_reset");
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done) ndone++;
        end
        check("midrun_reset.no_done", ndone, 0);
        run_op("after_reset", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 1'b1);

        // Random regression against a 33-bit sign-extended reference
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (rs) ext = {ra[31], ra} - {rb[31], rb};
            else    ext = {ra[31], ra} + {rb[31], rb};
            run_op($sformatf("rand%0d", k), ra, rb, rs, ext[31:0], ext[32] ^ ext[31],
                   (ext[31:0] != 32'd0), ext[32], 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
